// File: rtl/neuron_pkg.sv
// Shared types for the neuron time-step updater: packed neuron word layout,
// field offsets/widths and the sequencer state encoding.
package neuron_pkg;

  localparam int NR_WIDTH    = 56;
  localparam int NR_I_WIDTH  = 16;
  localparam int NR_V_WIDTH  = 16;
  localparam int NR_TH_WIDTH = 16;
  localparam int NR_LK_WIDTH = 4;
  localparam int NR_RF_WIDTH = 4;

  localparam int NR_I_LSB  = 0;
  localparam int NR_V_LSB  = 16;
  localparam int NR_TH_LSB = 32;
  localparam int NR_LK_LSB = 48;
  localparam int NR_RF_LSB = 52;

  // Arithmetic width: two guard bits so leak+integrate never overflows
  localparam int NR_ACC_WIDTH = NR_V_WIDTH + 2;

  typedef struct packed {
    logic [NR_RF_WIDTH-1:0] rf;
    logic [NR_LK_WIDTH-1:0] lk;
    logic [NR_TH_WIDTH-1:0] th;
    logic [NR_V_WIDTH-1:0]  v;
    logic [NR_I_WIDTH-1:0]  i;
  } neuron_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_UPDATE,
    ST_SPIKE,
    ST_DONE
  } upd_state_t;

endpackage

// File: rtl/neuron_lif_core.sv
// Combinational leaky integrate-and-fire step for one neuron word.
// NEURON_UPDATE_SAT_EN selects saturating (defined) or wrapping (undefined) V'.
module neuron_lif_core
  import neuron_pkg::*;
#(
  parameter int REFRAC_STEPS = 2
) (
  input  neuron_state_t state_i,
  output neuron_state_t state_o,
  output logic          spike_o
);

  localparam logic signed [NR_ACC_WIDTH-1:0] V_MAX = NR_ACC_WIDTH'((2 ** (NR_V_WIDTH - 1)) - 1);
  localparam logic signed [NR_ACC_WIDTH-1:0] V_MIN = -NR_ACC_WIDTH'(2 ** (NR_V_WIDTH - 1));

  logic signed [NR_ACC_WIDTH-1:0] v_ext;
  logic signed [NR_ACC_WIDTH-1:0] i_ext;
  logic signed [NR_ACC_WIDTH-1:0] th_ext;
  logic signed [NR_ACC_WIDTH-1:0] v_shr;
  logic signed [NR_ACC_WIDTH-1:0] v_leak;
  logic signed [NR_ACC_WIDTH-1:0] v_sum;
  logic        [NR_V_WIDTH-1:0]   v_next;

  always_comb begin
    v_ext  = {{(NR_ACC_WIDTH - NR_V_WIDTH){state_i.v[NR_V_WIDTH-1]}}, state_i.v};
    i_ext  = {{(NR_ACC_WIDTH - NR_I_WIDTH){state_i.i[NR_I_WIDTH-1]}}, state_i.i};
    th_ext = {{(NR_ACC_WIDTH - NR_TH_WIDTH){state_i.th[NR_TH_WIDTH-1]}}, state_i.th};
    v_shr  = v_ext >>> state_i.lk;
    // LK==0 means "no leak", not "leak everything"
    v_leak = (state_i.lk != '0) ? (v_ext - v_shr) : v_ext;
    v_sum  = v_leak + i_ext;
  end

`ifdef NEURON_UPDATE_SAT_EN
  always_comb begin
    if (v_sum > V_MAX)      v_next = V_MAX[NR_V_WIDTH-1:0];
    else if (v_sum < V_MIN) v_next = V_MIN[NR_V_WIDTH-1:0];
    else                    v_next = v_sum[NR_V_WIDTH-1:0];
  end
`else
  always_comb begin
    v_next = v_sum[NR_V_WIDTH-1:0];
  end
`endif

  // Threshold uses the full-width sum, before any wrap or clamp
  always_comb begin
    state_o   = state_i;
    state_o.i = '0;
    spike_o   = 1'b0;
    if (state_i.rf != '0) begin
      state_o.v  = '0;
      state_o.rf = state_i.rf - 1'b1;
    end else if (v_sum >= th_ext) begin
      spike_o    = 1'b1;
      state_o.v  = '0;
      state_o.rf = NR_RF_WIDTH'(REFRAC_STEPS);
    end else begin
      state_o.v  = v_next;
      state_o.rf = '0;
    end
  end

endmodule

// File: rtl/neuron_updater.sv
// Time-step sweep over the neuron state memory: read, LIF update, write back,
// emit spike events. Saturation of V' is selected by NEURON_UPDATE_SAT_EN.
//
// state     | meaning
// ST_IDLE   | waiting for start_i
// ST_READ   | read strobe for neuron addr_q
// ST_UPDATE | rdata valid, write back updated word
// ST_SPIKE  | spike event offered, held until spike_ready_i
// ST_DONE   | one-cycle done pulse
module neuron_updater
  import neuron_pkg::*;
#(
  parameter int N_NEURONS    = 256,
  parameter int ADDR_WIDTH   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
  parameter int REFRAC_STEPS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [NR_WIDTH-1:0]   mem_rdata_i,
  output logic                  mem_wr_en_o,
  output logic [NR_WIDTH-1:0]   mem_wdata_o,
  output logic                  spike_valid_o,
  output logic [ADDR_WIDTH-1:0] spike_addr_o,
  input  logic                  spike_ready_i
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_NEURONS - 1);

  upd_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  neuron_state_t         core_out;
  logic                  core_spike;
  logic                  last;

  neuron_lif_core #(
    .REFRAC_STEPS(REFRAC_STEPS)
  ) u_core (
    .state_i(neuron_state_t'(mem_rdata_i)),
    .state_o(core_out),
    .spike_o(core_spike)
  );

  assign last = (addr_q == LAST_ADDR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    mem_rd_en_o   = 1'b0;
    mem_wr_en_o   = 1'b0;
    mem_wdata_o   = '0;
    spike_valid_o = 1'b0;
    spike_addr_o  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_READ;
          addr_d  = '0;
        end
      end
      ST_READ: begin
        busy_o      = 1'b1;
        mem_rd_en_o = 1'b1;
        state_d     = ST_UPDATE;
      end
      ST_UPDATE: begin
        busy_o      = 1'b1;
        mem_wr_en_o = 1'b1;
        mem_wdata_o = core_out;
        if (core_spike) begin
          state_d = ST_SPIKE;
        end else if (last) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_READ;
        end
      end
      ST_SPIKE: begin
        busy_o        = 1'b1;
        spike_valid_o = 1'b1;
        spike_addr_o  = addr_q;
        if (spike_ready_i) begin
          if (last) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address is held in the counter between strobes; it stays 0 out of reset
  assign mem_addr_o = addr_q;

endmodule

// File: tb/tb_neuron_updater.sv
// Directed bench for neuron_updater with a 1-cycle-latency memory model.
module tb_neuron_updater;
  import neuron_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;

  logic          clk, rst, start, busy, done;
  logic          mem_rd_en, mem_wr_en, spike_valid, spike_ready;
  logic [AW-1:0] mem_addr, spike_addr;
  logic [55:0]   mem_rdata, mem_wdata;
  logic [55:0]   mem [N];

  int checks   = 0;
  int failures = 0;
  int spk_q[$];
  int cyc;

  neuron_updater #(.N_NEURONS(N), .REFRAC_STEPS(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_rd_en_o(mem_rd_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata),
    .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata),
    .spike_valid_o(spike_valid), .spike_addr_o(spike_addr), .spike_ready_i(spike_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] mk(input int rf, input int lk, input int th, input int v, input int i);
    return {4'(rf), 4'(lk), 16'(th), 16'(v), 16'(i)};
  endfunction

  task automatic poke(input int a, input logic [55:0] w);
    mem[a] <= w;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd"}, mem_rd_en, 0);
    check({tag, "_wr"}, mem_wr_en, 0);
    check({tag, "_sv"}, spike_valid, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
    check({tag, "_saddr"}, spike_addr, 0);
  endtask

  // One sweep; optionally withholds spike_ready for stall_len cycles on stall_addr
  task automatic run_sweep(input int stall_addr, input int stall_len, output int ncyc);
    int stall;
    int rd_idx;
    stall  = 0;
    rd_idx = 0;
    spk_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ncyc  = 1;
    while (!done && ncyc < 200) begin
      if (mem_rd_en) begin
        check("rd_order", mem_addr, rd_idx);
        rd_idx++;
      end
      if (stall > 0 && stall < stall_len) begin
        check("hold_valid", spike_valid, 1);
        check("hold_addr", spike_addr, stall_addr);
        check("stall_no_rd", mem_rd_en, 0);
      end
      if (spike_valid && spike_addr == stall_addr && stall < stall_len) begin
        spike_ready = 1'b0;
        stall++;
      end else begin
        spike_ready = 1'b1;
      end
      if (spike_valid && spike_ready) spk_q.push_back(int'(spike_addr));
      @(posedge clk); #1;
      ncyc++;
    end
    spike_ready = 1'b1;
    check("done_seen", done, 1);
    check("rd_count", rd_idx, N);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; spike_ready = 1'b1;
    mem_rdata = '0;
    #12;
    check_idle_outputs("reset");
    check("reset_state", dut.state_q, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    poke(0, mk(0, 0, 120, 100, 50));
    poke(1, mk(0, 2, 1000, 64, 10));
    poke(2, mk(2, 0, 10, 0, 500));
    poke(3, mk(0, 0, 5, 10, 10));
    poke(4, mk(0, 0, 32767, 32000, 2000));
    poke(5, mk(0, 0, 32767, 30000, 2000));
    poke(6, mk(0, 0, 32767, 32767, 100));
    poke(7, mk(0, 0, 0, -32000, -2000));

    // Sweep 1: spikes on 0,3,4,6; addr 3 back-pressured for 5 cycles
    run_sweep(3, 5, cyc);
    check("s1_cycles", cyc, 2 * N + 4 + 5 + 1);
    check("s1_nspk", spk_q.size(), 4);
    if (spk_q.size() == 4) begin
      check("s1_spk0", spk_q[0], 0);
      check("s1_spk1", spk_q[1], 3);
      check("s1_spk2", spk_q[2], 4);
      check("s1_spk3", spk_q[3], 6);
    end
    check("s1_m0", mem[0], mk(2, 0, 120, 0, 0));
    check("s1_m1", mem[1], mk(0, 2, 1000, 58, 0));
    check("s1_m2", mem[2], mk(1, 0, 10, 0, 0));
    check("s1_m3", mem[3], mk(2, 0, 5, 0, 0));
    check("s1_m4", mem[4], mk(2, 0, 32767, 0, 0));
    check("s1_m5", mem[5], mk(0, 0, 32767, 32000, 0));
    check("s1_m6", mem[6], mk(2, 0, 32767, 0, 0));
`ifdef NEURON_UPDATE_SAT_EN
    check("s1_m7", mem[7], mk(0, 0, 0, -32768, 0));
`else
    check("s1_m7", mem[7], mk(0, 0, 0, 31536, 0));
`endif
    @(posedge clk); #1;

    // Sweep 2: refractory countdown, leak on residual V, spike on last neuron
    poke(7, mk(0, 0, 1, 5, 5));
    run_sweep(-1, 0, cyc);
    check("s2_cycles", cyc, 2 * N + 1 + 1);
    check("s2_nspk", spk_q.size(), 1);
    if (spk_q.size() == 1) check("s2_spk0", spk_q[0], 7);
    check("s2_m0", mem[0], mk(1, 0, 120, 0, 0));
    check("s2_m1", mem[1], mk(0, 2, 1000, 44, 0));
    check("s2_m2", mem[2], mk(0, 0, 10, 0, 0));
    check("s2_m5", mem[5], mk(0, 0, 32767, 32000, 0));
    check("s2_m7", mem[7], mk(2, 0, 1, 0, 0));
    // start coincident with done must be ignored
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_start_busy", busy, 0);
    check("done_start_state", dut.state_q, ST_IDLE);
    @(posedge clk); #1;
    check("done_start_rd", mem_rd_en, 0);

    // Sweep 3: reset while reading neuron 5
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!(mem_rd_en && mem_addr == 3'd5) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reached", {mem_rd_en, 5'(mem_addr)}, {1'b1, 5'd5});
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    check("abort_state", dut.state_q, ST_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sweep 4: no spikes, nominal timing
    for (int a = 0; a < N; a++) poke(a, mk(0, 0, 100, 0, 0));
    run_sweep(-1, 0, cyc);
    check("s4_cycles", cyc, 2 * N + 1);
    check("s4_nspk", spk_q.size(), 0);
    @(posedge clk); #1;
    check("s4_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/neuron_updater.md
Name: neuron_updater

Overview:
- Time-step sequencer that consumes the neuron state words written by the synaptic accumulation path.
- On each `start` it sweeps the neuron state memory from address 0 to N_NEURONS-1.
- Per neuron it reads the packed word, applies leak, integrates the accumulated current I into membrane potential V, and checks the threshold.
- It writes the updated word back with I cleared and emits a spike event on a valid/ready stream.

Parameters:
- NR_WIDTH, 56, packed neuron word width.
- NR_I_WIDTH, 16, current field I, bits [15:0], signed.
- NR_V_WIDTH, 16, potential field V, bits [31:16], signed.
- NR_TH_WIDTH, 16, threshold field TH, bits [47:32], signed.
- N_NEURONS, 256, neurons per sweep.
- ADDR_WIDTH, $clog2(N_NEURONS), memory address width.
- REFRAC_STEPS, 2, refractory time steps reloaded after a spike (max 15).
- Fixed fields: LK, bits [51:48], unsigned leak shift. RF, bits [55:52], unsigned refractory counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse, begins a sweep.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse after the last neuron retires.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  ADDR_WIDTH  read/write address.
- mem_rdata  in  NR_WIDTH  read data, valid exactly 1 cycle after mem_rd_en.
- mem_wr_en  out  1  write strobe.
- mem_wdata  out  NR_WIDTH  write data.
- spike_valid  out  1  spike event valid.
- spike_addr  out  ADDR_WIDTH  index of the spiking neuron.
- spike_ready  in  1  downstream accept.

Behaviour:
- Reset: async and active-high. State goes to IDLE. busy, done, mem_rd_en, mem_wr_en and spike_valid are 0. mem_addr, mem_wdata and spike_addr are 0. The address counter is 0.
- Reset mid-sweep aborts immediately. Words already written stay written; there is no rollback.
- FSM states:
  - IDLE: start=1 → READ, addr=0, busy=1. start in any other state is ignored.
  - READ: mem_rd_en=1, mem_addr=addr → UPDATE.
  - UPDATE: mem_rdata valid. Compute, then mem_wr_en=1 with mem_addr=addr and mem_wdata=new word. If spiking → SPIKE. Else if addr==N_NEURONS-1 → DONE. Else addr+1 → READ.
  - SPIKE: spike_valid=1, spike_addr=addr. Hold until spike_ready=1. On the accept cycle, go to DONE if last, else addr+1 → READ.
    - spike_valid and spike_addr must stay stable while ready is low.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Throughput and latency:
  - 2 cycles per non-spiking neuron.
  - 3 cycles minimum per spiking neuron.
  - Sweep latency from start to done is 2*N_NEURONS + (number of spikes) + stall cycles + 1.
- Update arithmetic (signed, computed at NR_V_WIDTH+2 bits):
  - If RF != 0: V'=0, RF'=RF-1, no spike. The accumulated I is discarded.
  - Else:
    - Leak: Vl = V - (V >>> LK) when LK != 0; Vl = V when LK == 0.
    - Integrate: Vs = Vl + sign-extended I.
    - If Vs >= TH (signed compare): spike, V'=0, RF'=REFRAC_STEPS.
    - Else: V'=Vs truncated or saturated (see Optional Feature), RF'=0.
  - The threshold compare uses full-width Vs, before saturation or wrap.
  - Write-back: I'=0. TH and LK are passed through unchanged.
- Boundaries:
  - N_NEURONS=1 works: READ → UPDATE → DONE.
  - The address never wraps. The sweep ends at N_NEURONS-1.
  - start coincident with done: start is ignored, because it is not sampled in DONE.
  - spike_ready held high: no extra stall.
  - A spike on the last neuron: DONE follows the accept cycle.

Optional Feature:
- Macro NEURON_UPDATE_SAT_EN.
- Defined: V' saturates to [-2^(NR_V_WIDTH-1), 2^(NR_V_WIDTH-1)-1] when no spike occurs.
- Undefined: V' is Vs truncated to NR_V_WIDTH bits (two's-complement wrap).
- Spike decision is identical in both builds.

Decomposition:
- Package neuron_pkg holds:
  - field offset/width localparams for I, V, TH, LK, RF;
  - typedef struct packed neuron_state_t;
  - the FSM state enum upd_state_t.
- Sub-module neuron_lif_core: purely combinational. neuron_state_t in → neuron_state_t out plus a spike bit. It contains the leak, integrate, threshold and refractory logic.
- neuron_updater holds the FSM, address counter and handshake registers.

Test Plan:
- Threshold crossing: V=100, I=50, TH=120, LK=0, RF=0 → spike at that addr. Write-back V=0, RF=2, I=0, TH=120.
- Sub-threshold with leak: V=64, I=10, TH=1000, LK=2 → no spike, V'=58, I'=0.
- Refractory: RF=2, V=0, I=500, TH=10 → no spike, V'=0, RF'=1. Next sweep: RF'=0, no spike.
- Backpressure: spike on addr 3 with spike_ready low for 5 cycles → spike_valid and spike_addr=3 held stable. Addr 4 is not read until the accept cycle.
- Overflow: V=32000, I=2000, TH=32767.
  - With NEURON_UPDATE_SAT_EN defined: no spike (Vs=34000 ≥ TH) is false, so check spike=1.
  - With TH=-32768+… (set TH=32767, V=30000, I=2000, LK=0): Vs=32000 < TH → no spike, V'=32000 in both builds.
  - V=32767, I=100, TH=32767 → spike in both builds.
- Reset mid-sweep plus sweep timing: assert rst at addr 5 → all outputs 0 and IDLE on the same edge. A new start then sweeps 0..N-1. With no spikes, done arrives at cycle 2N+1 after start.
